// File: rtl/rr_mux_arbiter_if.sv
// Bus bundle for rr_mux_arbiter: the four request/data lanes, the downstream handshake,
// and the registered grant/select observation outputs.
//   req        4        per-requester request, bit k = requester k
//   din        4*DW     packed data lanes, lane k = din[k*DW +: DW]
//   out_ready  1        downstream accepts the current word
//   out_valid  1        dout holds a word from the granted requester
//   dout       DW       selected lane
//   sel        2        registered mux select (granted requester index)
//   gnt        4        registered one-hot grant, zero when idle
// master drives requests/data/ready; slave is the arbiter.
interface rr_mux_arbiter_if #(
  parameter int unsigned DW = 8
);
  logic [3:0]      req;
  logic [4*DW-1:0] din;
  logic            out_ready;
  logic            out_valid;
  logic [DW-1:0]   dout;
  logic [1:0]      sel;
  logic [3:0]      gnt;

  modport master (
    output req, din, out_ready,
    input  out_valid, dout, sel, gnt
  );

  modport slave (
    input  req, din, out_ready,
    output out_valid, dout, sel, gnt
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin 4:1 arbiter with data mux and bounded bursts.
// An idle cycle arbitrates among requesters starting at the priority pointer; the winner holds
// the grant for up to BURST accepted words, or until it drops its request, after which the
// pointer moves past it and the arbiter returns to idle for one cycle before re-arbitrating.
//   clk  1  clock, rising edge
//   rst  1  synchronous active-high reset
//   bus  rr_mux_arbiter_if.slave (req, din, out_ready in; out_valid, dout, sel, gnt out)
module rr_mux_arbiter #(
  parameter int unsigned DW    = 8,
  parameter int unsigned BURST = 4
) (
  input logic            clk,
  input logic            rst,
  rr_mux_arbiter_if.slave bus
);

  typedef enum logic {StIdle, StBusy} state_e;

  localparam logic [3:0] LastCnt = 4'(BURST - 1);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;

  logic [1:0] win;
  logic [1:0] cand;
  logic       found;
  logic       owner_req;

  // First requester at or after the pointer, wrapping modulo 4.
  always_comb begin
    win   = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && bus.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign owner_req = bus.req[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StBusy;
          sel_d   = win;
          gnt_d   = 4'b0001 << win;
          cnt_d   = 4'd0;
        end
      end
      StBusy: begin
        // A dropped request releases without a transfer even if out_ready is high.
        if (!owner_req || (bus.out_ready && cnt_q == LastCnt)) begin
          state_d = StIdle;
          gnt_d   = 4'd0;
          cnt_d   = 4'd0;
          ptr_d   = sel_q + 2'd1;
        end else if (bus.out_ready) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 4'd0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= 2'd0;
      gnt_q   <= 4'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid = (state_q == StBusy) && owner_req;
  assign bus.dout      = bus.din[sel_q*DW +: DW];
  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter: DW, default 8, width of each requester data lane.
REQ-002 Parameter: BURST, default 4, max transfers per grant; legal range 1..16.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset; sampled only on the rising edge of clk.
REQ-005 Port: req  input  4  per-requester request; bit k = requester k.
REQ-006 Port: din  input  4*DW  packed lanes; lane k = din[k*DW +: DW].
REQ-007 Port: out_ready  input  1  downstream accepts the current word.
REQ-008 Port: out_valid  output  1  dout holds a word from the granted requester.
REQ-009 Port: dout  output  DW  selected lane (4:1 mux output).
REQ-010 Port: sel  output  2  registered mux select = index of granted requester.
REQ-011 Port: gnt  output  4  registered one-hot grant; all-zero when idle.

Function
REQ-012 Two states SHALL exist: IDLE and BUSY.
REQ-013 Registered state SHALL be: state, sel, gnt, ptr (2-bit priority pointer), cnt (4-bit transfer count).
REQ-014 In IDLE: gnt=0, out_valid=0, sel holds its last value.
REQ-015 In IDLE, if req!=0 at an edge, the winner SHALL be the first k in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[k]=1.
REQ-016 At that edge: state->BUSY, sel=winner, gnt=onehot(winner), cnt=0; request-to-grant latency is exactly 1 cycle.
REQ-017 In IDLE with req=0, all state SHALL hold.
REQ-018 In BUSY: out_valid = req[sel] (combinational); dout = din lane sel (combinational); gnt stable.
REQ-019 A transfer occurs on an edge where out_valid=1 and out_ready=1.
REQ-020 Transfer with cnt<BURST-1: cnt increments; state stays BUSY.
REQ-021 Transfer with cnt=BURST-1: release.
REQ-022 req[sel]=0 at any BUSY edge: release with no transfer, including when out_ready=1 on that edge.
REQ-023 Release: state->IDLE, gnt=0, cnt=0, ptr=(sel+1) mod 4 (2-bit wrap, 3->0).
REQ-024 Minimum gap between two grants SHALL be one IDLE cycle; re-arbitration occurs in that IDLE cycle.
REQ-025 out_ready=0 in BUSY with req[sel]=1: all state holds indefinitely; no timeout.
REQ-026 Changes on non-granted req bits during BUSY SHALL be ignored until the next IDLE arbitration.
REQ-027 dout SHALL be don't-care when out_valid=0; bench checks dout only when out_valid=1.

Reset
REQ-028 rst=1 at an edge: state=IDLE, sel=0, gnt=0, ptr=0, cnt=0; out_valid=0 from the following cycle.
REQ-029 rst SHALL override all other inputs, including mid-burst; an in-flight word is dropped and not counted.
REQ-030 After reset, requester 0 SHALL have highest priority.

Verification
REQ-031 Reset, then req=0001, out_ready=1, DW=8, lane0=8'hA5 held -> gnt=0001 one cycle later; 4 transfers of A5; release; ptr=1.
REQ-032 req=1111 held, out_ready=1 -> grant order 0,1,2,3,0; each grant carries 4 transfers; one IDLE cycle between grants.
REQ-033 req=0100 granted; out_ready=0 for 5 cycles, then 1 -> out_valid=1 for all 5 stalled cycles; cnt stays 0; 4 transfers follow.
REQ-034 req=0010 granted; after 2 transfers, req[1] drops while out_ready=1 -> no transfer on that edge; release; ptr=2.
REQ-035 Mid-burst rst=1 for 1 cycle with req=1000 held -> gnt=0 and out_valid=0 next cycle; re-grant to requester 3 one cycle after rst deasserts, cnt restarts at 0.
REQ-036 ptr=3 with req=1001 -> requester 3 wins; after its release ptr=0 and requester 0 wins.
